// File: rtl/rv32_mem_access_pkg.sv
// Shared types for the rv32 memory stage: access widths, FSM states and the
// captured-transaction record held while the bus is busy.
package rv32_mem_access_pkg;

  localparam logic [1:0] RV32_MEM_WIDTH_BYTE = 2'b00;
  localparam logic [1:0] RV32_MEM_WIDTH_HALF = 2'b01;
  localparam logic [1:0] RV32_MEM_WIDTH_WORD = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic [31:0] result;
    logic        read;
    logic        write;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic [1:0]  width;
    logic        zext;
    logic [4:0]  rd;
    logic        rd_write;
  } mem_txn_t;

  // Bytes are always aligned; unknown width encodings are treated as word.
  function automatic logic is_aligned(input logic [1:0] width, input logic [1:0] lo);
    case (width)
      RV32_MEM_WIDTH_BYTE: is_aligned = 1'b1;
      RV32_MEM_WIDTH_HALF: is_aligned = ~lo[0];
      default:             is_aligned = (lo == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/rv32_mem_access_load_align.sv
// Picks the addressed byte/half out of a bus read word and sign- or
// zero-extends it to 32 bits.
module rv32_load_align
  import rv32_mem_access_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [1:0]  width_i,
  input  logic        zero_ext_i,
  output logic [31:0] value_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_lane = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    value_o   = rdata_i;
    case (width_i)
      RV32_MEM_WIDTH_BYTE: value_o = {{24{~zero_ext_i & byte_lane[7]}}, byte_lane};
      RV32_MEM_WIDTH_HALF: value_o = {{16{~zero_ext_i & half_lane[15]}}, half_lane};
      default:             value_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/rv32_mem_access.sv
// Memory stage: issues load/store requests on a request/ready data bus, stalls
// the pipeline while a request is outstanding, and registers the writeback fields.
module rv32_mem_access
  import rv32_mem_access_pkg::*;
(
  input  logic        clk,
  input  logic        reset_,
  input  logic        stall_in,
  input  logic        flush_in,
  input  logic        valid_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [1:0]  mem_width_in,
  input  logic        mem_zero_extend_in,
  input  logic        mem_fence_in,
  input  logic [4:0]  rd_in,
  input  logic        rd_write_in,
  input  logic [31:0] result_in,
  input  logic [31:0] rs2_value_in,
  output logic [31:0] data_address_out,
  output logic        data_read_out,
  output logic        data_write_out,
  output logic [3:0]  data_write_mask_out,
  output logic [31:0] data_write_value_out,
  input  logic        data_ready_in,
  input  logic [31:0] data_read_value_in,
  output logic        mem_stall_out,
  output logic        misaligned_out,
  output logic        valid_out,
  output logic [4:0]  rd_out,
  output logic        rd_write_out,
  output logic [31:0] rd_value_out
);

  // Bus handshake: a request (data_read_out/data_write_out) is held with
  // address, mask and data stable until the cycle data_ready_in=1, in which the
  // bus accepts it and (for reads) returns data_read_value_in; the request drops
  // the following cycle unless a new access is presented.

  mem_state_e  state_q, state_d;
  mem_txn_t    txn_q, txn_d, cur_txn, act_txn;
  logic        flushed_q, flushed_d;
  logic        valid_q, valid_d, rd_write_q, rd_write_d, mis_q, mis_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] rd_value_q, rd_value_d, load_value;
  logic        busy, is_mem, aligned, access, misaligned, req, discard;

  always_comb begin
    cur_txn          = '0;
    cur_txn.result   = result_in;
    cur_txn.read     = mem_read_in;
    cur_txn.write    = mem_write_in;
    cur_txn.width    = mem_width_in;
    cur_txn.zext     = mem_zero_extend_in;
    cur_txn.rd       = rd_in;
    cur_txn.rd_write = rd_write_in;
    case (mem_width_in)
      RV32_MEM_WIDTH_BYTE: begin
        cur_txn.mask  = 4'b0001 << result_in[1:0];
        cur_txn.wdata = {4{rs2_value_in[7:0]}};
      end
      RV32_MEM_WIDTH_HALF: begin
        cur_txn.mask  = 4'b0011 << result_in[1:0];
        cur_txn.wdata = {2{rs2_value_in[15:0]}};
      end
      default: begin
        cur_txn.mask  = 4'b1111;
        cur_txn.wdata = rs2_value_in;
      end
    endcase
  end

  assign busy       = (state_q == ST_BUSY);
  assign is_mem     = valid_in & ~mem_fence_in & (mem_read_in | mem_write_in);
  assign aligned    = is_aligned(mem_width_in, result_in[1:0]);
  assign access     = is_mem & ~flush_in & aligned;
  assign misaligned = is_mem & ~flush_in & ~aligned;
  // In BUSY the captured transaction keeps the request alive even across a flush.
  assign act_txn    = busy ? txn_q : cur_txn;
  assign req        = reset_ & (busy | access);
  assign discard    = flushed_q | flush_in;

  assign mem_stall_out        = req & ~data_ready_in;
  assign data_address_out     = req ? {act_txn.result[31:2], 2'b00} : 32'h0;
  assign data_read_out        = req & act_txn.read;
  assign data_write_out       = req & act_txn.write;
  assign data_write_mask_out  = (req & act_txn.write) ? act_txn.mask : 4'b0000;
  assign data_write_value_out = (req & act_txn.write) ? act_txn.wdata : 32'h0;

  rv32_load_align u_load_align (
    .rdata_i    (data_read_value_in),
    .addr_lo_i  (act_txn.result[1:0]),
    .width_i    (act_txn.width),
    .zero_ext_i (act_txn.zext),
    .value_o    (load_value)
  );

  always_comb begin
    state_d    = state_q;
    txn_d      = txn_q;
    flushed_d  = busy ? discard : 1'b0;
    valid_d    = valid_q;
    rd_d       = rd_q;
    rd_write_d = rd_write_q;
    rd_value_d = rd_value_q;
    mis_d      = mis_q;
    if (!busy && access) begin
      txn_d = cur_txn;
      if (!data_ready_in) state_d = ST_BUSY;
    end else if (busy && data_ready_in) begin
      state_d = ST_IDLE;
    end
    if (!stall_in) begin
      valid_d    = 1'b0;
      rd_d       = 5'd0;
      rd_write_d = 1'b0;
      rd_value_d = 32'h0;
      mis_d      = 1'b0;
      if (mem_stall_out) begin
        // bubble while the bus is outstanding
      end else if (busy) begin
        if (!discard) begin
          valid_d    = 1'b1;
          rd_d       = txn_q.rd;
          rd_write_d = txn_q.rd_write & txn_q.read;
          rd_value_d = txn_q.read ? load_value : txn_q.result;
        end
      end else if (!flush_in) begin
        valid_d    = valid_in;
        rd_d       = rd_in;
        rd_write_d = valid_in & rd_write_in & ~mem_write_in & ~misaligned;
        rd_value_d = (access && mem_read_in) ? load_value : result_in;
        mis_d      = misaligned;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q    <= ST_IDLE;
      txn_q      <= '0;
      flushed_q  <= 1'b0;
      valid_q    <= 1'b0;
      rd_q       <= 5'd0;
      rd_write_q <= 1'b0;
      rd_value_q <= 32'h0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      txn_q      <= txn_d;
      flushed_q  <= flushed_d;
      valid_q    <= valid_d;
      rd_q       <= rd_d;
      rd_write_q <= rd_write_d;
      rd_value_q <= rd_value_d;
      mis_q      <= mis_d;
    end
  end

  assign valid_out      = valid_q;
  assign rd_out         = rd_q;
  assign rd_write_out   = rd_write_q;
  assign rd_value_out   = rd_value_q;
  assign misaligned_out = mis_q;

endmodule

// File: tb/tb_rv32_mem_access.sv
// Directed bench for the rv32 memory stage: loads, stores, misalignment,
// flush during a busy store, reset mid-transaction and stall hold.
module tb_rv32_mem_access;
  import rv32_mem_access_pkg::*;

  logic        clk, reset_, stall_in, flush_in, valid_in, mem_read_in, mem_write_in;
  logic [1:0]  mem_width_in;
  logic        mem_zero_extend_in, mem_fence_in, rd_write_in, data_ready_in;
  logic [4:0]  rd_in;
  logic [31:0] result_in, rs2_value_in, data_read_value_in;
  logic [31:0] data_address_out, data_write_value_out, rd_value_out;
  logic        data_read_out, data_write_out, mem_stall_out, misaligned_out;
  logic        valid_out, rd_write_out;
  logic [3:0]  data_write_mask_out;
  logic [4:0]  rd_out;

  int tests = 0;
  int fails = 0;
  int wr_count;

  rv32_mem_access dut (
    .clk(clk), .reset_(reset_), .stall_in(stall_in), .flush_in(flush_in),
    .valid_in(valid_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .mem_width_in(mem_width_in), .mem_zero_extend_in(mem_zero_extend_in),
    .mem_fence_in(mem_fence_in), .rd_in(rd_in), .rd_write_in(rd_write_in),
    .result_in(result_in), .rs2_value_in(rs2_value_in),
    .data_address_out(data_address_out), .data_read_out(data_read_out),
    .data_write_out(data_write_out), .data_write_mask_out(data_write_mask_out),
    .data_write_value_out(data_write_value_out), .data_ready_in(data_ready_in),
    .data_read_value_in(data_read_value_in), .mem_stall_out(mem_stall_out),
    .misaligned_out(misaligned_out), .valid_out(valid_out), .rd_out(rd_out),
    .rd_write_out(rd_write_out), .rd_value_out(rd_value_out)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver
  task automatic drive(input logic v, input logic rd_en, input logic wr_en,
                       input logic [1:0] w, input logic z, input logic [4:0] rd,
                       input logic rdw, input logic [31:0] res, input logic [31:0] rs2);
    valid_in           = v;
    mem_read_in        = rd_en;
    mem_write_in       = wr_en;
    mem_width_in       = w;
    mem_zero_extend_in = z;
    rd_in              = rd;
    rd_write_in        = rdw;
    result_in          = res;
    rs2_value_in       = rs2;
  endtask

  initial begin
    reset_ = 1'b1; stall_in = 1'b0; flush_in = 1'b0; mem_fence_in = 1'b0;
    data_ready_in = 1'b0; data_read_value_in = 32'h0;
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
    #1 reset_ = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, valid_out}, 32'd0);
    chk("rst_rdwr", {31'b0, rd_write_out}, 32'd0);
    chk("rst_value", rd_value_out, 32'h0);
    chk("rst_stall", {31'b0, mem_stall_out}, 32'd0);
    chk("rst_req", {30'b0, data_read_out, data_write_out}, 32'd0);
    chk("rst_state", {31'b0, dut.state_q}, {31'b0, ST_IDLE});
    @(negedge clk) reset_ = 1'b1;

    // LW 0x100, zero-wait
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, RV32_MEM_WIDTH_WORD, 1'b0, 5'd5, 1'b1, 32'h100, 32'h0);
    data_ready_in = 1'b1; data_read_value_in = 32'hDEADBEEF;
    #1;
    chk("lw_read", {31'b0, data_read_out}, 32'd1);
    chk("lw_addr", data_address_out, 32'h100);
    chk("lw_stall", {31'b0, mem_stall_out}, 32'd0);
    @(posedge clk); #1;
    chk("lw_valid", {31'b0, valid_out}, 32'd1);
    chk("lw_value", rd_value_out, 32'hDEADBEEF);
    chk("lw_rd", {27'b0, rd_out}, 32'd5);
    chk("lw_rdwr", {31'b0, rd_write_out}, 32'd1);

    // LB 0x103, ready after 3 stall cycles
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, RV32_MEM_WIDTH_BYTE, 1'b0, 5'd6, 1'b1, 32'h103, 32'h0);
    data_ready_in = 1'b0; data_read_value_in = 32'h0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      chk("lb_stall", {31'b0, mem_stall_out}, 32'd1);
      chk("lb_addr", data_address_out, 32'h100);
      chk("lb_read", {31'b0, data_read_out}, 32'd1);
      @(posedge clk); #1;
      chk("lb_bubble", {31'b0, valid_out}, 32'd0);
    end
    @(negedge clk);
    data_ready_in = 1'b1; data_read_value_in = 32'h80FFFFFF;
    #1;
    chk("lb_stall_end", {31'b0, mem_stall_out}, 32'd0);
    chk("lb_read_held", {31'b0, data_read_out}, 32'd1);
    @(posedge clk); #1;
    chk("lb_value", rd_value_out, 32'hFFFFFF80);
    chk("lb_valid", {31'b0, valid_out}, 32'd1);
    chk("lb_rd", {27'b0, rd_out}, 32'd6);

    // LBU 0x103 zero-wait
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, RV32_MEM_WIDTH_BYTE, 1'b1, 5'd6, 1'b1, 32'h103, 32'h0);
    @(posedge clk); #1;
    chk("lbu_value", rd_value_out, 32'h00000080);

    // SH 0x102
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, RV32_MEM_WIDTH_HALF, 1'b0, 5'd0, 1'b0, 32'h102, 32'h1234ABCD);
    data_ready_in = 1'b1;
    #1;
    chk("sh_write", {31'b0, data_write_out}, 32'd1);
    chk("sh_read", {31'b0, data_read_out}, 32'd0);
    chk("sh_mask", {28'b0, data_write_mask_out}, 32'hC);
    chk("sh_data", data_write_value_out, 32'hABCDABCD);
    @(posedge clk); #1;
    chk("sh_valid", {31'b0, valid_out}, 32'd1);
    chk("sh_rdwr", {31'b0, rd_write_out}, 32'd0);

    // LW 0x101 misaligned
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, RV32_MEM_WIDTH_WORD, 1'b0, 5'd8, 1'b1, 32'h101, 32'h0);
    data_ready_in = 1'b0;
    #1;
    chk("mis_read", {31'b0, data_read_out}, 32'd0);
    chk("mis_stall", {31'b0, mem_stall_out}, 32'd0);
    @(posedge clk); #1;
    chk("mis_pulse", {31'b0, misaligned_out}, 32'd1);
    chk("mis_valid", {31'b0, valid_out}, 32'd1);
    chk("mis_rdwr", {31'b0, rd_write_out}, 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    chk("mis_once", {31'b0, misaligned_out}, 32'd0);

    // SW 0x200, flush pulsed while busy, ready two cycles after issue
    wr_count = 0;
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, RV32_MEM_WIDTH_WORD, 1'b0, 5'd0, 1'b0, 32'h200, 32'hCAFEF00D);
    data_ready_in = 1'b0;
    #1;
    chk("sw_write", {31'b0, data_write_out}, 32'd1);
    chk("sw_mask", {28'b0, data_write_mask_out}, 32'hF);
    @(negedge clk);
    flush_in = 1'b1;
    #1;
    chk("sw_flush_write", {31'b0, data_write_out}, 32'd1);
    chk("sw_flush_data", data_write_value_out, 32'hCAFEF00D);
    chk("sw_flush_stall", {31'b0, mem_stall_out}, 32'd1);
    @(negedge clk);
    flush_in = 1'b0; data_ready_in = 1'b1;
    #1;
    if (data_write_out && data_ready_in) wr_count++;
    chk("sw_done_addr", data_address_out, 32'h200);
    @(posedge clk); #1;
    chk("sw_discard", {31'b0, valid_out}, 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0);
    #1;
    if (data_write_out && data_ready_in) wr_count++;
    chk("sw_write_once", wr_count, 32'd1);

    // reset during BUSY
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, RV32_MEM_WIDTH_WORD, 1'b0, 5'd9, 1'b1, 32'h300, 32'h0);
    data_ready_in = 1'b0;
    @(posedge clk); #1;
    chk("rb_busy", {31'b0, dut.state_q}, {31'b0, ST_BUSY});
    #2 reset_ = 1'b0;
    #1;
    chk("rb_read", {31'b0, data_read_out}, 32'd0);
    chk("rb_stall", {31'b0, mem_stall_out}, 32'd0);
    chk("rb_outs", {valid_out, rd_write_out, misaligned_out, rd_out}, 32'd0);
    chk("rb_state", {31'b0, dut.state_q}, {31'b0, ST_IDLE});

    // ALU pass-through and stall_in hold
    @(negedge clk);
    reset_ = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 5'd7, 1'b1, 32'h55, 32'h0);
    #1;
    chk("alu_noreq", {30'b0, data_read_out, data_write_out}, 32'd0);
    @(posedge clk); #1;
    chk("alu_value", rd_value_out, 32'h55);
    chk("alu_rdwr", {31'b0, rd_write_out}, 32'd1);
    @(negedge clk);
    stall_in = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 5'd3, 1'b1, 32'h66, 32'h0);
    @(posedge clk); #1;
    chk("stall_hold_value", rd_value_out, 32'h55);
    chk("stall_hold_rd", {27'b0, rd_out}, 32'd7);
    @(negedge clk);
    stall_in = 1'b0;
    @(posedge clk); #1;
    chk("stall_release", rd_value_out, 32'h66);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
